// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the sync_ram copy engine.
//   RAM_DATA_W     - width of one RAM word (32)
//   DEFAULT_ADDR_W - default RAM address width (8, i.e. 256 words)
//   copy_state_e   - copy-engine FSM states
package ram_pkg;

    localparam int RAM_DATA_W     = 32;
    localparam int DEFAULT_ADDR_W = 8;

    typedef enum logic [2:0] {
        CE_IDLE = 3'd0,
        CE_RD   = 3'd1,
        CE_CAP  = 3'd2,
        CE_WR   = 3'd3,
        CE_DONE = 3'd4
    } copy_state_e;

endpackage

// File: rtl/ram_copy_engine_if.sv
// ram_copy_engine_if: port bundle between the copy engine and sync_ram.
//   ram_addr [ADDR_WIDTH] - RAM addr     (engine -> RAM)
//   ram_din  [32]         - RAM Din      (engine -> RAM)
//   ram_we                - RAM writeEn  (engine -> RAM)
//   ram_rd                - RAM read     (engine -> RAM)
//   ram_dout [32]         - RAM Dout     (RAM -> engine)
// Modports: master (copy engine), slave (RAM).
interface ram_copy_engine_if #(
    parameter int ADDR_WIDTH = ram_pkg::DEFAULT_ADDR_W
);
    import ram_pkg::*;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [RAM_DATA_W-1:0] ram_din;
    logic                  ram_we;
    logic                  ram_rd;
    logic [RAM_DATA_W-1:0] ram_dout;

    modport master (
        output ram_addr, ram_din, ram_we, ram_rd,
        input  ram_dout
    );

    modport slave (
        input  ram_addr, ram_din, ram_we, ram_rd,
        output ram_dout
    );

endinterface

// File: rtl/copy_addr_gen.sv
// copy_addr_gen: holds the latched copy parameters and the word index.
//   clk, rst  - clock, asynchronous active-high reset
//   load      - latch new_src/new_dst/new_len and clear the index
//   inc       - advance the index by one word
//   new_src   - first source address to latch
//   new_dst   - first destination address to latch
//   new_len   - word count to latch (0..2^ADDR_WIDTH)
//   src_word  - src + i, wrapped to the RAM size
//   dst_word  - dst + i, wrapped to the RAM size
//   last      - current word is the final one (i+1 == len)
module copy_addr_gen
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] new_src,
    input  logic [ADDR_WIDTH-1:0] new_dst,
    input  logic [ADDR_WIDTH:0]   new_len,
    output logic [ADDR_WIDTH-1:0] src_word,
    output logic [ADDR_WIDTH-1:0] dst_word,
    output logic                  last
);

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH:0]   len_q;
    // One bit wider than an address so that a full-RAM copy can count to 2^ADDR_WIDTH.
    logic [ADDR_WIDTH:0]   idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            src_q <= new_src;
            dst_q <= new_dst;
            len_q <= new_len;
            idx_q <= '0;
        end else if (inc) begin
            idx_q <= idx_q + ONE;
        end
    end

    // Dropping the index MSB gives the modulo-2^ADDR_WIDTH wrap for free.
    assign src_word = src_q + idx_q[ADDR_WIDTH-1:0];
    assign dst_word = dst_q + idx_q[ADDR_WIDTH-1:0];
    assign last     = ((idx_q + ONE) == len_q);

endmodule

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies len words from src_addr to dst_addr inside one
// single-port sync_ram, three cycles per word (RD, CAP, WR), ascending order.
//   clk, rst  - clock, asynchronous active-high reset
//   start     - copy request, honoured only when idle
//   src_addr  - first source word address (latched at start)
//   dst_addr  - first destination word address (latched at start)
//   len       - word count 0..2^ADDR_WIDTH (latched at start)
//   busy      - high while words are being moved
//   done      - one-cycle completion pulse
//   checksum  - sum mod 2^32 of all captured words (only with COPY_CHECKSUM_EN)
//   ram       - RAM port bundle (master side)
// Build option: define COPY_CHECKSUM_EN to add the checksum port and adder.
module ram_copy_engine
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
`ifdef COPY_CHECKSUM_EN
    output logic [RAM_DATA_W-1:0] checksum,
`endif
    ram_copy_engine_if.master     ram
);

    copy_state_e           state;
    logic [RAM_DATA_W-1:0] data_q;
    logic [ADDR_WIDTH-1:0] src_word;
    logic [ADDR_WIDTH-1:0] dst_word;
    logic                  last;
    logic                  load;
    logic                  in_rd;

    assign load = (state == CE_IDLE) && start;

    copy_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .inc      (state == CE_WR),
        .new_src  (src_addr),
        .new_dst  (dst_addr),
        .new_len  (len),
        .src_word (src_word),
        .dst_word (dst_word),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CE_IDLE;
        end else begin
            case (state)
                CE_IDLE: if (start) state <= (len == '0) ? CE_DONE : CE_RD;
                CE_RD:   state <= CE_CAP;
                CE_CAP:  state <= CE_WR;
                CE_WR:   state <= last ? CE_DONE : CE_RD;
                CE_DONE: state <= CE_IDLE;
                default: state <= CE_IDLE;
            endcase
        end
    end

    // Dout is only guaranteed driven in CAP (read held high a second cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (state == CE_CAP) begin
            data_q <= ram.ram_dout;
        end
    end

`ifdef COPY_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (load) begin
            checksum <= '0;
        end else if (state == CE_CAP) begin
            checksum <= checksum + ram.ram_dout;
        end
    end
`endif

    // Outputs decode the state register only, so they never follow inputs
    // combinationally and fall as soon as the asynchronous reset hits.
    assign in_rd        = (state == CE_RD) || (state == CE_CAP);
    assign busy         = in_rd || (state == CE_WR);
    assign done         = (state == CE_DONE);
    assign ram.ram_rd   = in_rd;
    assign ram.ram_we   = (state == CE_WR);
    assign ram.ram_din  = data_q;
    assign ram.ram_addr = in_rd             ? src_word :
                          (state == CE_WR)  ? dst_word : '0;

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: bench for ram_copy_engine with a behavioural sync_ram,
// a per-cycle reference model of the copy timing and a forward-copy shadow RAM.
// Define COPY_CHECKSUM_EN for both bench and RTL to exercise the checksum port.
module tb_ram_copy_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] src_addr = 8'h00;
    logic [7:0] dst_addr = 8'h00;
    logic [8:0] len = 9'd0;
    logic       busy;
    logic       done;
`ifdef COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    ram_copy_engine_if #(.ADDR_WIDTH(8)) bus ();

    ram_copy_engine #(
        .ADDR_WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
`ifdef COPY_CHECKSUM_EN
        .checksum (checksum),
`endif
        .ram      (bus)
    );

    // ---------------- sync_ram model with a backdoor preload port ----------------
    logic [31:0] mem [0:255];
    logic [31:0] dout_reg = 32'h0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'h00;
    logic [31:0] pre_data = 32'h0;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_din;
        if (bus.ram_rd)
            dout_reg <= mem[bus.ram_addr];
    end

    // Undriven Dout is represented by a recognisable junk pattern.
    assign bus.ram_dout = (bus.ram_rd || bus.ram_we) ? dout_reg : 32'hDEAD_BEEF;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // cyc = cycle number since the accepted start (1 = first cycle after it), -1 when idle.
    int          cyc = -1;
    int          m_len = 0;
    logic [7:0]  m_src = 8'h00;
    logic [7:0]  m_dst = 8'h00;
    logic [31:0] exp_din [0:255];
    logic [31:0] exp_sum = 32'h0;
    logic [31:0] shadow  [0:255];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= -1;
        end else if (cyc == -1) begin
            if (start) begin
                cyc   <= 1;
                m_src <= src_addr;
                m_dst <= dst_addr;
                m_len <= int'(len);
            end
        end else if (cyc >= 3 * m_len + 1) begin
            cyc <= -1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    // Forward copy on a snapshot of the RAM: gives the word written for each index.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
        logic [7:0]  sa;
        logic [7:0]  da;
        logic [31:0] v;
        for (int a = 0; a < 256; a++) shadow[a] = mem[a];
        exp_sum = 32'h0;
        for (int k = 0; k < int'(l); k++) begin
            sa = s + 8'(k);
            da = d + 8'(k);
            v  = shadow[sa];
            exp_din[k] = v;
            shadow[da] = v;
            exp_sum    = exp_sum + v;
        end
    endtask

    function automatic bit in_word(input int c);
        return (c >= 1) && (c <= 3 * m_len);
    endfunction

    function automatic int phase(input int c);
        return (c - 1) % 3;
    endfunction

    function automatic int word(input int c);
        return (c - 1) / 3;
    endfunction

    function automatic logic [7:0] exp_addr(input int c);
        if (phase(c) < 2) return m_src + 8'(word(c));
        return m_dst + 8'(word(c));
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(in_word(cyc)));
            chk("done", 32'(done), 32'((cyc >= 1) && (cyc == 3 * m_len + 1)));
            chk("ram_rd", 32'(bus.ram_rd), 32'(in_word(cyc) && (phase(cyc) < 2)));
            chk("ram_we", 32'(bus.ram_we), 32'(in_word(cyc) && (phase(cyc) == 2)));
            if (in_word(cyc))
                chk("ram_addr", 32'(bus.ram_addr), 32'(exp_addr(cyc)));
            if (in_word(cyc) && (phase(cyc) == 2))
                chk("ram_din", bus.ram_din, exp_din[word(cyc)]);
`ifdef COPY_CHECKSUM_EN
            if ((cyc >= 1) && (cyc == 3 * m_len + 1))
                chk("checksum", checksum, exp_sum);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic poke(input logic [7:0] a, input logic [31:0] v);
        pre_addr = a;
        pre_data = v;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Called at a negedge while the engine is idle; returns at the negedge of cycle 1.
    task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
        model_copy(s, d, l);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int dc, output int busy_n,
                             output int strobe_n, output logic [31:0] cs);
        dc = -1; busy_n = 0; strobe_n = 0; cs = 32'h0;
        for (int c = 1; c <= lim; c++) begin
            if (bus.ram_rd || bus.ram_we) strobe_n++;
            if (busy) busy_n++;
            if (done) begin
                dc = c;
`ifdef COPY_CHECKSUM_EN
                cs = checksum;
`endif
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) chk("done_timeout", 32'h0, 32'h1);
        @(negedge clk);
    endtask

    task automatic copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                        output int dc, output int busy_n, output int strobe_n,
                        output logic [31:0] cs);
        issue(s, d, l);
        wait_done(3 * int'(l) + 10, dc, busy_n, strobe_n, cs);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int          dc;
        int          bn;
        int          sn;
        logic [31:0] cs;
        logic [31:0] old9;
        logic [31:0] old91;
        logic [31:0] old61;

        // Reset state
        @(negedge clk);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_we",    32'(bus.ram_we), 32'h0);
        chk("rst_rd",    32'(bus.ram_rd), 32'h0);
        chk("rst_addr",  32'(bus.ram_addr), 32'h0);
        chk("rst_din",   bus.ram_din, 32'h0);
`ifdef COPY_CHECKSUM_EN
        chk("rst_checksum", checksum, 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Basic 4-word copy
        poke(8'h00, 32'h11); poke(8'h01, 32'h22); poke(8'h02, 32'h33); poke(8'h03, 32'h44);
        copy(8'h00, 8'h80, 9'd4, dc, bn, sn, cs);
        chk("t1_done_cycle", 32'(dc), 32'd13);
        chk("t1_busy_cycles", 32'(bn), 32'd12);
        chk("t1_m80", mem[8'h80], 32'h11);
        chk("t1_m81", mem[8'h81], 32'h22);
        chk("t1_m82", mem[8'h82], 32'h33);
        chk("t1_m83", mem[8'h83], 32'h44);

        // Zero-length copy
        old9 = mem[8'h09];
        copy(8'h05, 8'h09, 9'd0, dc, bn, sn, cs);
        chk("t2_done_cycle", 32'(dc), 32'd1);
        chk("t2_strobes", 32'(sn), 32'd0);
        chk("t2_busy", 32'(bn), 32'd0);
        chk("t2_m09", mem[8'h09], old9);

        // Address wrap
        poke(8'hFE, 32'hA); poke(8'hFF, 32'hB); poke(8'h00, 32'hC);
        copy(8'hFE, 8'h01, 9'd3, dc, bn, sn, cs);
        chk("t3_m01", mem[8'h01], 32'hA);
        chk("t3_m02", mem[8'h02], 32'hB);
        chk("t3_m03", mem[8'h03], 32'hC);

        // Overlapping forward copy
        poke(8'h10, 32'h1); poke(8'h11, 32'h2);
        copy(8'h10, 8'h11, 9'd2, dc, bn, sn, cs);
        chk("t4_m11", mem[8'h11], 32'h1);
        chk("t4_m12", mem[8'h12], 32'h1);

        // Whole-RAM copy onto itself
        copy(8'h40, 8'h40, 9'd256, dc, bn, sn, cs);
        chk("t5_done_cycle", 32'(dc), 32'd769);
        chk("t5_m80", mem[8'h80], 32'h11);

        // Start ignored while busy, then asynchronous reset in cycle 5
        old91 = mem[8'h91];
        old61 = mem[8'h61];
        issue(8'h80, 8'h90, 9'd4);          // now in cycle 1
        @(negedge clk);                     // cycle 2
        src_addr = 8'h10; dst_addr = 8'h61; len = 9'd1; start = 1'b1;
        @(negedge clk);                     // cycle 3
        start = 1'b0;
        @(negedge clk);                     // cycle 4
        @(negedge clk);                     // cycle 5
        chk("t6_rd_before", 32'(bus.ram_rd), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_rd", 32'(bus.ram_rd), 32'h0);
        chk("t6_we", 32'(bus.ram_we), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_addr", 32'(bus.ram_addr), 32'h0);
        chk("t6_din", bus.ram_din, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_m90", mem[8'h90], 32'h11);
        chk("t6_m91", mem[8'h91], old91);
        chk("t6_m61", mem[8'h61], old61);

        // Engine is usable again after the reset
        copy(8'h80, 8'h94, 9'd2, dc, bn, sn, cs);
        chk("t7_done_cycle", 32'(dc), 32'd7);
        chk("t7_m94", mem[8'h94], 32'h11);
        chk("t7_m95", mem[8'h95], 32'h22);

`ifdef COPY_CHECKSUM_EN
        // Checksum wraps modulo 2^32
        poke(8'h20, 32'hFFFF_FFFF); poke(8'h21, 32'h0000_0002);
        copy(8'h20, 8'h30, 9'd2, dc, bn, sn, cs);
        chk("t8_checksum", cs, 32'h0000_0001);
        chk("t8_checksum_hold", checksum, 32'h0000_0001);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
